// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment receive path: active-low glyphs (g..a)
// for hex codes 0..F, the blank pattern and the snapshot state encoding.
package seg_pkg;

   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [0:0] SNAP_IDLE = 1'b0;
   localparam logic [0:0] SNAP_HOLD = 1'b1;

endpackage

// File: rtl/seg_pattern_to_hex.sv
// Inverse of the hex-to-segment decoder: maps one active-low segment pattern
// back to its hex code; anything outside the 16 glyphs is flagged not legal.
module seg_pattern_to_hex
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] code,
   output logic       legal
);

   always_comb begin
      code  = 4'h0;
      legal = 1'b1;
      case (pattern)
         SEG_HEX_0: code = 4'h0;
         SEG_HEX_1: code = 4'h1;
         SEG_HEX_2: code = 4'h2;
         SEG_HEX_3: code = 4'h3;
         SEG_HEX_4: code = 4'h4;
         SEG_HEX_5: code = 4'h5;
         SEG_HEX_6: code = 4'h6;
         SEG_HEX_7: code = 4'h7;
         SEG_HEX_8: code = 4'h8;
         SEG_HEX_9: code = 4'h9;
         SEG_HEX_A: code = 4'hA;
         SEG_HEX_B: code = 4'hB;
         SEG_HEX_C: code = 4'hC;
         SEG_HEX_D: code = 4'hD;
         SEG_HEX_E: code = 4'hE;
         SEG_HEX_F: code = 4'hF;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_pattern_receiver.sv
// Captures NUM_DIGITS segment buses, filters each digit until it has been stable
// for STABLE_CYCLES samples, decodes it and offers the word as a held snapshot.
//
// state     | meaning
// SNAP_IDLE | no snapshot pending; loads one as soon as a commit has changed a digit
// SNAP_HOLD | out_valid high, outputs frozen until out_ready
module seg_pattern_receiver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7*NUM_DIGITS-1:0] seg_n,
   output logic [4*NUM_DIGITS-1:0] out_data,
   output logic [NUM_DIGITS-1:0]   out_err,
   output logic [NUM_DIGITS-1:0]   out_known,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam logic [3:0] SC_MAX  = 4'(STABLE_CYCLES);
   localparam logic [3:0] SC_LAST = 4'(STABLE_CYCLES - 1);

   logic [7*NUM_DIGITS-1:0] s1, s2;
   logic [4*NUM_DIGITS-1:0] hex;
   logic [NUM_DIGITS-1:0]   err, known, changed;
   logic [0:0]              state;
   logic                    dirty;

   // seg_n may come straight from pins in another clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= seg_n;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [6:0] pin, prev;
      logic [3:0] cnt, code, hex_q;
      logic       legal, err_q, known_q, commit;

      assign pin = s2[7*i +: 7];

      seg_pattern_to_hex u_dec (
         .pattern (prev),
         .code    (code),
         .legal   (legal)
      );

      // saturating count means a held pattern commits exactly once
      assign commit     = (pin == prev) && (cnt == SC_LAST);
      assign changed[i] = commit && (legal ? (err_q || (hex_q != code)) : !err_q);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prev <= '0;
            cnt  <= '0;
         end else if (pin != prev) begin
            prev <= pin;
            cnt  <= '0;
         end else if (cnt < SC_MAX) begin
            cnt <= cnt + 4'd1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hex_q   <= '0;
            err_q   <= 1'b0;
            known_q <= 1'b0;
         end else if (commit) begin
            if (legal) begin
               hex_q   <= code;
               err_q   <= 1'b0;
               known_q <= 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end
      end

      assign hex[4*i +: 4] = hex_q;
      assign err[i]        = err_q;
      assign known[i]      = known_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SNAP_IDLE;
         out_data  <= '0;
         out_err   <= '0;
         out_known <= '0;
      end else begin
         case (state)
            SNAP_IDLE: begin
               if (dirty) begin
                  out_data  <= hex;
                  out_err   <= err;
                  out_known <= known;
                  state     <= SNAP_HOLD;
               end
            end
            default: begin
               if (out_ready) state <= SNAP_IDLE;
            end
         endcase
      end
   end

   // a change landing on the load cycle must survive the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dirty <= 1'b0;
      end else if (|changed) begin
         dirty <= 1'b1;
      end else if ((state == SNAP_IDLE) && dirty) begin
         dirty <= 1'b0;
      end
   end

   assign out_valid = (state == SNAP_HOLD);

endmodule

// File: tb/tb_seg_pattern_receiver.sv
// Bench for seg_pattern_receiver: directed scenarios plus random pin activity,
// compared against a pin-level model of the settle/commit/snapshot rules.
module tb_seg_pattern_receiver;

   localparam int ND = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7*ND-1:0] seg_n;
   logic [4*ND-1:0] out_data;
   logic [ND-1:0] out_err, out_known;
   logic          out_valid;
   logic          out_ready;

   always #5 clk = ~clk;

   seg_pattern_receiver #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_n     (seg_n),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_known (out_known),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a digit commits once its pin value has been sampled SC+1 times in a row.
   // Reset leaves SC-1 implicit samples of 7'h00 in the pipeline.
   logic [3:0] m_hex   [ND];
   logic       m_err   [ND];
   logic       m_known [ND];
   logic [6:0] m_val   [ND];
   int         m_run   [ND];

   function automatic int decode(input logic [6:0] p);
      for (int c = 0; c < 16; c++) if (seg_tab[c] == p) return c;
      return -1;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (rst) begin
            m_hex[d] = 4'h0; m_err[d] = 1'b0; m_known[d] = 1'b0;
            m_val[d] = 7'h00; m_run[d] = SC - 1;
         end else begin
            logic [6:0] p;
            int c;
            p = seg_n[7*d +: 7];
            if (p == m_val[d]) begin
               if (m_run[d] < 1000) m_run[d]++;
            end else begin
               m_val[d] = p;
               m_run[d] = 1;
            end
            if (m_run[d] == SC + 1) begin
               c = decode(p);
               if (c >= 0) begin
                  m_hex[d] = 4'(c); m_err[d] = 1'b0; m_known[d] = 1'b1;
               end else begin
                  m_err[d] = 1'b1;
               end
            end
         end
      end
   end

   function automatic logic [4*ND-1:0] model_data();
      logic [4*ND-1:0] r;
      for (int d = 0; d < ND; d++) r[4*d +: 4] = m_hex[d];
      return r;
   endfunction

   function automatic logic [ND-1:0] model_err();
      logic [ND-1:0] r;
      for (int d = 0; d < ND; d++) r[d] = m_err[d];
      return r;
   endfunction

   function automatic logic [ND-1:0] model_known();
      logic [ND-1:0] r;
      for (int d = 0; d < ND; d++) r[d] = m_known[d];
      return r;
   endfunction

   // Transfer log and frozen-while-held check, sampled mid-cycle
   logic [4*ND-1:0] last_data;
   logic [ND-1:0]   last_err, last_known;
   logic [4*ND+2*ND-1:0] held_snap;
   logic            held = 1'b0;
   int              snaps = 0;

   always @(negedge clk) begin
      if (!rst && held)
         check("hold_frozen", 32'({out_data, out_err, out_known}), 32'(held_snap));
      held      = out_valid && !out_ready;
      held_snap = {out_data, out_err, out_known};
      if (out_valid && out_ready) begin
         snaps++;
         last_data  = out_data;
         last_err   = out_err;
         last_known = out_known;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_digit(input int d, input logic [6:0] p);
      seg_n[7*d +: 7] = p;
   endtask

   task automatic check_vs_model(input string tag);
      check({tag, "_data"},  32'(last_data),  32'(model_data()));
      check({tag, "_err"},   32'(last_err),   32'(model_err()));
      check({tag, "_known"}, 32'(last_known), 32'(model_known()));
   endtask

   initial begin
      int base;
      int k;
      logic [4*ND-1:0] first;

      out_ready = 1'b1;
      seg_n = {7'h40, 7'h40, 7'h40, 7'h24};
      step(2);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_data",  32'({out_data, out_err, out_known}), 32'd0);
      rst = 1'b0;

      step(7);
      check("lat_early", 32'(out_valid), 32'd0);
      step(1);
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_data",  32'(out_data),  32'h0002);
      check("lat_err",   32'(out_err),   32'h0);
      check("lat_known", 32'(out_known), 32'hF);
      step(10);
      check("first_snaps", 32'(snaps), 32'd1);
      check_vs_model("first");

      // loopback of every code through digit1, starting from an error state
      set_digit(1, 7'h7F);
      step(20);
      base = snaps;
      for (int c = 0; c < 16; c++) begin
         set_digit(1, seg_tab[c]);
         step(20);
         check("loop_count", 32'(snaps), 32'(base + c + 1));
         check("loop_code",  32'(last_data[7:4]), 32'(c));
         check("loop_err",   32'(last_err), 32'h0);
      end
      check_vs_model("loop");

      // toggles shorter than the settle window
      base = snaps;
      for (int t = 0; t < 10; t++) begin
         set_digit(2, (t % 2 == 0) ? 7'h30 : 7'h19);
         step(3);
      end
      check("toggle_quiet", 32'(snaps), 32'(base));
      step(20);
      check("toggle_snap",  32'(snaps), 32'(base + 1));
      check("toggle_code",  32'(last_data[11:8]), 32'h4);
      check("toggle_err",   32'(last_err[2]), 32'h0);

      // blank is illegal: flag it, keep the previous code and known bit
      set_digit(3, 7'h7F);
      step(20);
      check("blank_err",   32'(last_err[3]), 32'h1);
      check("blank_data",  32'(last_data[15:12]), 32'h0);
      check("blank_known", 32'(last_known[3]), 32'h1);
      check_vs_model("blank");

      // backpressure while two digits commit
      out_ready = 1'b0;
      set_digit(0, seg_tab[5]);
      step(20);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_d0",    32'(out_data[3:0]), 32'h5);
      check("bp_d1",    32'(out_data[7:4]), 32'hF);
      first = out_data;
      set_digit(1, seg_tab[7]);
      step(20);
      check("bp_frozen", 32'(out_data), 32'(first));
      out_ready = 1'b1;
      step(1);
      check("bp_gap", 32'(out_valid), 32'd0);
      step(1);
      check("bp_second_valid", 32'(out_valid), 32'd1);
      check("bp_second_d0",    32'(out_data[3:0]), 32'h5);
      check("bp_second_d1",    32'(out_data[7:4]), 32'h7);
      step(5);

      // random pin activity with random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < 100; n++) begin
            for (int d = 0; d < ND; d++) begin
               if ($urandom_range(0, 5) == 0) begin
                  if ($urandom_range(0, 3) == 0) set_digit(d, 7'($urandom_range(0, 127)));
                  else                           set_digit(d, seg_tab[$urandom_range(0, 15)]);
               end
            end
            out_ready = 1'($urandom_range(0, 1));
            step(1);
         end
         out_ready = 1'b1;
         step(20);
         check("rand_idle", 32'(out_valid), 32'd0);
         check_vs_model("rand");
      end

      // reset while a snapshot is held and a digit is mid-filter
      out_ready = 1'b0;
      set_digit(0, seg_tab[9]);
      set_digit(2, seg_tab[3]);
      set_digit(3, seg_tab[6]);
      step(12);
      set_digit(1, seg_tab[10]);
      step(3);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(out_valid), 32'd0);
      check("rst_async_out",   32'({out_data, out_err, out_known}), 32'd0);
      step(2);
      rst = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (k < 20) begin
         step(1);
         k++;
         if (out_valid) break;
      end
      check("rst_relatency", 32'(k), 32'(4 + SC));
      check("rst_data",  32'(out_data),  32'(model_data()));
      check("rst_err",   32'(out_err),   32'(model_err()));
      check("rst_known", 32'(out_known), 32'(model_known()));
      step(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
